// File: rtl/lot_sim_responder.sv
// Behavioural parking-lot model driven by gate-open commands: an entrance
// gate, an exit gate and three spots, each reported as a registered sensor.
module lot_sim_responder #(
   parameter int PASS_CYCLES  = 4,
   parameter int GATE_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       car_arrive,
   input  logic       car_depart,
   input  logic       open_entrance,
   input  logic       open_exit,
   output logic       pres_entrance,
   output logic       pres_exit,
   output logic [2:0] pres_spot,
   output logic [1:0] car_count,
   output logic       balk,
   output logic       req_drop,
   output logic       overflow
);

   localparam int WW = $clog2(GATE_TIMEOUT + 1);
   localparam int PW = $clog2(PASS_CYCLES + 1);
   localparam logic [WW-1:0] WAIT_LIM = WW'(GATE_TIMEOUT);
   localparam logic [PW-1:0] PASS_LD  = PW'(PASS_CYCLES);
   localparam logic [PW-1:0] PASS_END = PW'(1);

   typedef enum logic [1:0] {E_IDLE, E_WAIT, E_PASS} ent_state_t;
   typedef enum logic [1:0] {X_IDLE, X_WAIT, X_PASS} ext_state_t;

   ent_state_t    ent_q, ent_d;
   ext_state_t    ext_q, ext_d;
   logic [WW-1:0] wait_cnt, wait_d, wait_inc;
   logic [PW-1:0] ent_pass, ent_pass_d, ext_pass, ext_pass_d;
   logic          pres_ent_d, pres_exit_d, balk_d, drop_d, ovf_d, park;
   logic [2:0]    spot_clr, spot_mid, spot_set, spot_d;
   logic [1:0]    count_d;

   always_comb begin
      ent_d       = ent_q;
      ext_d       = ext_q;
      wait_d      = wait_cnt;
      wait_inc    = wait_cnt + 1'b1;
      ent_pass_d  = ent_pass;
      ext_pass_d  = ext_pass;
      pres_ent_d  = pres_entrance;
      pres_exit_d = pres_exit;
      balk_d      = 1'b0;
      drop_d      = 1'b0;
      ovf_d       = overflow;
      park        = 1'b0;
      spot_clr    = 3'b000;

      case (ent_q)
         E_IDLE: begin
            if (car_arrive) begin
               ent_d      = E_WAIT;
               wait_d     = '0;
               pres_ent_d = 1'b1;
            end
         end
         E_WAIT: begin
            // a gate opening on the timeout cycle still admits the car
            if (open_entrance) begin
               ent_d      = E_PASS;
               ent_pass_d = PASS_LD;
            end else if (wait_inc == WAIT_LIM) begin
               ent_d      = E_IDLE;
               wait_d     = '0;
               pres_ent_d = 1'b0;
               balk_d     = 1'b1;
            end else begin
               wait_d = wait_inc;
            end
         end
         E_PASS: begin
            if (ent_pass == PASS_END) begin
               ent_d      = E_IDLE;
               pres_ent_d = 1'b0;
               park       = 1'b1;
            end else begin
               ent_pass_d = ent_pass - 1'b1;
            end
         end
         default: ent_d = E_IDLE;
      endcase
      if (car_arrive && ent_q != E_IDLE) drop_d = 1'b1;

      case (ext_q)
         X_IDLE: begin
            if (car_depart && pres_spot != 3'b000) begin
               ext_d       = X_WAIT;
               spot_clr    = pres_spot & (~pres_spot + 3'd1);
               pres_exit_d = 1'b1;
            end else if (car_depart) begin
               drop_d = 1'b1;
            end
         end
         X_WAIT: begin
            if (open_exit) begin
               ext_d      = X_PASS;
               ext_pass_d = PASS_LD;
            end
         end
         X_PASS: begin
            if (ext_pass == PASS_END) begin
               ext_d       = X_IDLE;
               pres_exit_d = 1'b0;
            end else begin
               ext_pass_d = ext_pass - 1'b1;
            end
         end
         default: ext_d = X_IDLE;
      endcase
      if (car_depart && ext_q != X_IDLE) drop_d = 1'b1;

      // the departing car leaves first, so a parking car may reuse its spot
      spot_mid = pres_spot & ~spot_clr;
      spot_set = ~spot_mid & (spot_mid + 3'd1);
      spot_d   = spot_mid;
      if (park) begin
         if (spot_mid == 3'b111) ovf_d  = 1'b1;
         else                    spot_d = spot_mid | spot_set;
      end
      count_d = {1'b0, spot_d[0]} + {1'b0, spot_d[1]} + {1'b0, spot_d[2]};
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ent_q         <= E_IDLE;
         ext_q         <= X_IDLE;
         wait_cnt      <= '0;
         ent_pass      <= '0;
         ext_pass      <= '0;
         pres_entrance <= 1'b0;
         pres_exit     <= 1'b0;
         pres_spot     <= 3'b000;
         car_count     <= 2'd0;
         balk          <= 1'b0;
         req_drop      <= 1'b0;
         overflow      <= 1'b0;
      end else begin
         ent_q         <= ent_d;
         ext_q         <= ext_d;
         wait_cnt      <= wait_d;
         ent_pass      <= ent_pass_d;
         ext_pass      <= ext_pass_d;
         pres_entrance <= pres_ent_d;
         pres_exit     <= pres_exit_d;
         pres_spot     <= spot_d;
         car_count     <= count_d;
         balk          <= balk_d;
         req_drop      <= drop_d;
         overflow      <= ovf_d;
      end
   end

endmodule

// File: doc/lot_sim_responder.md
LOT_SIM_RESPONDER -- requirements
Module: lot_sim_responder

Purpose: behavioural parking-lot model on the far side of the V_GPIO interface. It consumes gate-open commands and produces presence sensor levels for 3 spots, entrance and exit.

Interface
REQ-001 Parameter PASS_CYCLES, default 4, cycles a car occupies a gate after the gate opens.
REQ-002 Parameter GATE_TIMEOUT, default 16, cycles an arriving car waits for the entrance gate before balking.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 car_arrive  input  1  one-cycle request: a new car arrives at the entrance.
REQ-006 car_depart  input  1  one-cycle request: a parked car leaves toward the exit.
REQ-007 open_entrance  input  1  entrance gate-open command from the controller (level).
REQ-008 open_exit  input  1  exit gate-open command from the controller (level).
REQ-009 pres_entrance  output  1  entrance presence sensor.
REQ-010 pres_exit  output  1  exit presence sensor.
REQ-011 pres_spot  output  3  spot presence sensors; bit i = spot i+1 occupied.
REQ-012 car_count  output  2  number of occupied spots, 0..3.
REQ-013 balk  output  1  one-cycle pulse: an arriving car gave up waiting.
REQ-014 req_drop  output  1  one-cycle pulse: an arrive or depart request was ignored.
REQ-015 overflow  output  1  sticky flag: a car was admitted with no free spot.

Function
REQ-016 The entrance FSM SHALL have states E_IDLE, E_WAIT and E_PASS.
- E_IDLE with car_arrive=1 -> E_WAIT.
- pres_entrance SHALL be 1 from the following cycle.
REQ-017 In E_WAIT:
- The wait counter SHALL increment every cycle.
- open_entrance=1 sampled -> E_PASS, with the pass counter loaded to PASS_CYCLES.
- Counter reaching GATE_TIMEOUT without open_entrance -> E_IDLE, pres_entrance=0, balk pulsed once.
REQ-018 In E_PASS:
- pres_entrance SHALL stay 1 for exactly PASS_CYCLES cycles.
- open_entrance SHALL be ignored.
- Then -> E_IDLE: pres_entrance=0 and the lowest-index clear bit of pres_spot set, in the same cycle.
REQ-019 If no spot is free at E_PASS completion, pres_spot SHALL be unchanged and overflow SHALL set; the car is discarded.
REQ-020 The exit FSM SHALL have states X_IDLE, X_WAIT and X_PASS.
- X_IDLE with car_depart=1 and pres_spot!=0 -> X_WAIT.
- The lowest-index set bit of pres_spot SHALL clear and pres_exit SHALL be 1 from the following cycle.
REQ-021 In X_WAIT the car SHALL wait indefinitely, with no timeout; open_exit=1 sampled -> X_PASS.
REQ-022 In X_PASS:
- pres_exit SHALL stay 1 for PASS_CYCLES cycles.
- Then -> X_IDLE with pres_exit=0.
REQ-023 req_drop SHALL pulse for one cycle in each of these cases:
- car_arrive while the entrance FSM is not in E_IDLE;
- car_depart while the exit FSM is not in X_IDLE;
- car_depart while pres_spot==0.
REQ-024 open_entrance in E_IDLE and open_exit in X_IDLE SHALL have no effect.
REQ-025 The two FSMs SHALL run independently.
- On the same cycle, a spot set by E_PASS completion and a spot cleared by a depart request SHALL both take effect.
- Clear is evaluated on the pre-update pres_spot; set targets the lowest bit free after the clear.
REQ-026 car_count SHALL equal the popcount of pres_spot, registered in the same cycle pres_spot updates.
REQ-027 balk and req_drop SHALL never be high for two consecutive cycles from a single event.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 reset=0 on a rising edge SHALL force, from the next cycle:
- E_IDLE and X_IDLE;
- pres_entrance=0, pres_exit=0, pres_spot=000, car_count=0;
- balk=0, req_drop=0, overflow=0;
- all counters cleared.
REQ-030 Reset mid-operation SHALL abandon in-flight cars without setting any flag.
REQ-031 Requests sampled while reset=0 SHALL be ignored.

Verification (PASS_CYCLES=4, GATE_TIMEOUT=16)
REQ-032 Arrive, then open_entrance 3 cycles later -> pres_entrance high for 3+4 cycles, then pres_spot=001 and car_count=1.
REQ-033 Arrive with open_entrance held 0 -> pres_entrance high 16 cycles, then 0 with balk pulsed once; pres_spot unchanged.
REQ-034 Three admitted arrivals, then a 4th admitted arrival -> pres_spot=111, car_count=3, overflow=1 and remaining 1.
REQ-035 pres_spot=011, car_depart -> pres_spot=010; pres_exit held until open_exit, then 4 cycles; car_depart issued again during X_WAIT -> req_drop pulse.
REQ-036 E_PASS completing on the same cycle as a depart request with pres_spot=111 -> spot 1 cleared and re-set, pres_spot=111, car_count=3, overflow=0.
REQ-037 reset=0 during E_PASS with pres_spot=101 -> next cycle all outputs 0; the following car_arrive is accepted normally.
